if_axi_fetch: RTL and testbench

//  IF-stage AXI4 read master. Fetches one 32-bit instruction per PC over the AR/R channels.

---
 rtl/if_axi_fetch_if.sv | 27 ++
 rtl/if_axi_fetch.sv | 127 ++++++++++++
 tb/tb_if_axi_fetch.sv | 556 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_axi_fetch_if.sv
// AXI4 read-only channel bundle (AR + R) between the IF fetch
// master and the instruction-side interconnect.
interface if_axi_fetch_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/if_axi_fetch.sv
// IF-stage AXI4 read master: one 32-bit single-beat fetch per PC,
// stall request while in flight, hold buffer for downstream stalls.
module if_axi_fetch #(
  parameter logic [3:0]  AXI_ID   = 4'd0,
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst_n,
  input  logic [31:0] pc,
  input  logic        pc_valid,
  input  logic        flush,
  input  logic [3:0]  stall,
  output logic        stallreq_if,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        inst_err,
  if_axi_fetch_if.master axi
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] buf_q, buf_d;
  logic        buf_err_q, buf_err_d;
  logic        drop_q, drop_d;

  logic        beat_done;
  logic        rsp_err;
  logic [31:0] rsp_inst;
  logic        unused_ok;

  assign beat_done = axi.rvalid & axi.rlast
                   & (axi.rid == AXI_ID);
  assign rsp_err   = axi.rresp != 2'b00;
  assign rsp_inst  = rsp_err ? 32'h0 : axi.rdata;
  assign unused_ok = ^{stall[3:2], stall[0], pc[1:0]};

  assign axi.arid    = AXI_ID;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = 3'b010;
  assign axi.arburst = 2'b01;
  assign axi.araddr  = addr_q;

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= RESET_PC;
      buf_q     <= 32'h0;
      buf_err_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      buf_q     <= buf_d;
      buf_err_q <= buf_err_d;
      drop_q    <= drop_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    buf_d       = buf_q;
    buf_err_d   = buf_err_q;
    drop_d      = drop_q;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    stallreq_if = 1'b0;
    inst        = 32'h0;
    inst_valid  = 1'b0;
    inst_err    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        stallreq_if = pc_valid;
        if (pc_valid && !flush) begin
          addr_d  = {pc[31:2], 2'b00};
          state_d = S_AR;
        end
      end
      S_AR: begin
        axi.arvalid = 1'b1;
        stallreq_if = 1'b1;
        if (flush) drop_d = 1'b1;
        if (axi.arready) state_d = S_R;
      end
      S_R: begin
        axi.rready  = 1'b1;
        stallreq_if = !(beat_done && !drop_q);
        inst        = rsp_inst;
        // a redirect landing on the final beat still discards it
        if (beat_done) begin
          state_d = S_IDLE;
          if (drop_q || flush) begin
            drop_d = 1'b0;
          end else if (!stall[1]) begin
            inst_valid = 1'b1;
            inst_err   = rsp_err;
          end else begin
            buf_d     = rsp_inst;
            buf_err_d = rsp_err;
            state_d   = S_HOLD;
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        inst = buf_q;
        if (flush) begin
          state_d = S_IDLE;
        end else if (!stall[1]) begin
          inst_valid = 1'b1;
          inst_err   = buf_err_q;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_if_axi_fetch.sv
// Self-checking bench for if_axi_fetch: directed scenarios plus a
// randomized fetch stream checked against an expected-delivery queue.
module tb_if_axi_fetch;
  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        pc_valid;
  logic        flush;
  logic [3:0]  stall;
  logic        stallreq_if;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  if_axi_fetch_if bus();

  if_axi_fetch #(
    .AXI_ID  (4'd0),
    .RESET_PC(RST_PC)
  ) dut (
    .cpu_clk    (clk),
    .cpu_rst_n  (rst_n),
    .pc         (pc),
    .pc_valid   (pc_valid),
    .flush      (flush),
    .stall      (stall),
    .stallreq_if(stallreq_if),
    .inst       (inst),
    .inst_valid (inst_valid),
    .inst_err   (inst_err),
    .axi        (bus.master)
  );

  task automatic quiet();
    pc_valid     = 1'b0;
    flush        = 1'b0;
    stall        = 4'b0000;
    bus.arready  = 1'b0;
    bus.rvalid   = 1'b0;
    bus.rlast    = 1'b0;
    bus.rid      = 4'd0;
    bus.rdata    = 32'h0;
    bus.rresp    = 2'b00;
  endtask

  task automatic beat(input logic [31:0] d, input logic [1:0] r);
    bus.rvalid = 1'b1;
    bus.rlast  = 1'b1;
    bus.rid    = 4'd0;
    bus.rdata  = d;
    bus.rresp  = r;
  endtask

  task automatic test_reset();
    quiet();
    bus.arready = 1'b1;
    bus.rvalid  = 1'b1;
    bus.rlast   = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({bus.arvalid, bus.rready, inst_valid, stallreq_if} !== 4'b0000) begin
      n_bad++;
      $display("FAIL rst_ctrl got=%b want=0000",
               {bus.arvalid, bus.rready, inst_valid, stallreq_if});
    end
    n_cmp++;
    if (bus.araddr !== RST_PC) begin
      n_bad++;
      $display("FAIL rst_araddr got=%h want=%h", bus.araddr, RST_PC);
    end
    n_cmp++;
    if ({inst_err, inst} !== 33'h0) begin
      n_bad++;
      $display("FAIL rst_inst got=%h want=0", {inst_err, inst});
    end
    @(negedge clk);
    rst_n = 1'b1;
    quiet();
    #1;
    n_cmp++;
    if ({bus.arvalid, bus.araddr} !== {1'b0, RST_PC}) begin
      n_bad++;
      $display("FAIL rst_release got=%h want=%h",
               {bus.arvalid, bus.araddr}, {1'b0, RST_PC});
    end
  endtask

  task automatic test_basic();
    @(negedge clk);
    pc = 32'hBFC0_0004; pc_valid = 1'b1; bus.arready = 1'b1;
    #1;
    n_cmp++;
    if ({stallreq_if, bus.arvalid, inst_valid} !== 3'b100) begin
      n_bad++;
      $display("FAIL basic_idle got=%b want=100",
               {stallreq_if, bus.arvalid, inst_valid});
    end
    @(negedge clk);
    pc_valid = 1'b0;
    #1;
    n_cmp++;
    if ({bus.arvalid, stallreq_if, inst_valid, bus.araddr}
        !== {3'b110, 32'hBFC0_0004}) begin
      n_bad++;
      $display("FAIL basic_ar got=%b/%h want=110/bfc00004",
               {bus.arvalid, stallreq_if, inst_valid}, bus.araddr);
    end
    n_cmp++;
    if ({bus.arid, bus.arlen, bus.arsize, bus.arburst}
        !== {4'd0, 8'd0, 3'b010, 2'b01}) begin
      n_bad++;
      $display("FAIL basic_arconst got=%h want=%h",
               {bus.arid, bus.arlen, bus.arsize, bus.arburst},
               {4'd0, 8'd0, 3'b010, 2'b01});
    end
    @(negedge clk);
    bus.arready = 1'b0;
    beat(32'h2408_0001, 2'b00);
    #1;
    n_cmp++;
    if ({bus.rready, inst_valid, inst_err, stallreq_if, inst}
        !== {4'b1100, 32'h2408_0001}) begin
      n_bad++;
      $display("FAIL basic_r got=%b/%h want=1100/24080001",
               {bus.rready, inst_valid, inst_err, stallreq_if}, inst);
    end
    @(negedge clk);
    quiet();
    #1;
    n_cmp++;
    if ({inst_valid, stallreq_if, bus.arvalid, bus.rready} !== 4'b0000) begin
      n_bad++;
      $display("FAIL basic_after got=%b want=0000",
               {inst_valid, stallreq_if, bus.arvalid, bus.rready});
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    @(negedge clk);
    pc = 32'h0000_1003; pc_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pc_valid = 1'b0;
      pc = $urandom;
      #1;
      n_cmp++;
      if ({bus.arvalid, stallreq_if, bus.araddr} !== {2'b11, 32'h0000_1000}) begin
        n_bad++;
        $display("FAIL bp_stable[%0d] got=%b/%h want=11/00001000",
                 i, {bus.arvalid, stallreq_if}, bus.araddr);
      end
    end
    @(negedge clk);
    bus.arready = 1'b1;
    #1;
    @(negedge clk);
    bus.arready = 1'b0;
    #1;
    n_cmp++;
    if ({bus.arvalid, bus.rready, stallreq_if, inst_valid} !== 4'b0110) begin
      n_bad++;
      $display("FAIL bp_rwait got=%b want=0110",
               {bus.arvalid, bus.rready, stallreq_if, inst_valid});
    end
    @(negedge clk);
    d = $urandom;
    beat(d, 2'b00);
    #1;
    n_cmp++;
    if ({inst_valid, inst_err, inst} !== {2'b10, d}) begin
      n_bad++;
      $display("FAIL bp_deliver got=%h want=%h",
               {inst_valid, inst_err, inst}, {2'b10, d});
    end
    @(negedge clk);
    quiet();
  endtask

  task automatic test_stall();
    @(negedge clk);
    pc = 32'h0000_2000; pc_valid = 1'b1; bus.arready = 1'b1;
    @(negedge clk);
    pc_valid = 1'b0;
    @(negedge clk);
    bus.arready = 1'b0;
    beat(32'h1234_5678, 2'b00);
    stall = 4'b0111;
    #1;
    n_cmp++;
    if ({inst_valid, stallreq_if} !== 2'b00) begin
      n_bad++;
      $display("FAIL stall_beat got=%b want=00", {inst_valid, stallreq_if});
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.rvalid = 1'b0;
      bus.rlast  = 1'b0;
      #1;
      n_cmp++;
      if ({inst_valid, stallreq_if, bus.arvalid, inst}
          !== {3'b000, 32'h1234_5678}) begin
        n_bad++;
        $display("FAIL stall_hold[%0d] got=%b/%h want=000/12345678",
                 i, {inst_valid, stallreq_if, bus.arvalid}, inst);
      end
    end
    @(negedge clk);
    stall = 4'b0000;
    #1;
    n_cmp++;
    if ({inst_valid, inst_err, inst} !== {2'b10, 32'h1234_5678}) begin
      n_bad++;
      $display("FAIL stall_release got=%h want=%h",
               {inst_valid, inst_err, inst}, {2'b10, 32'h1234_5678});
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (inst_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_once got=%b want=0", inst_valid);
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    pc = 32'h0000_0400; pc_valid = 1'b1; bus.arready = 1'b1;
    @(negedge clk);
    pc_valid = 1'b0;
    @(negedge clk);
    bus.arready = 1'b0;
    flush = 1'b1; pc = 32'h8000_0010; pc_valid = 1'b1;
    #1;
    n_cmp++;
    if ({stallreq_if, inst_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL flush_r got=%b want=10", {stallreq_if, inst_valid});
    end
    @(negedge clk);
    flush = 1'b0;
    beat(32'hDEAD_BEEF, 2'b00);
    #1;
    n_cmp++;
    if ({stallreq_if, inst_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL flush_drop got=%b want=10", {stallreq_if, inst_valid});
    end
    @(negedge clk);
    bus.rvalid = 1'b0; bus.rlast = 1'b0;
    #1;
    n_cmp++;
    if ({stallreq_if, bus.arvalid, inst_valid} !== 3'b100) begin
      n_bad++;
      $display("FAIL flush_idle got=%b want=100",
               {stallreq_if, bus.arvalid, inst_valid});
    end
    @(negedge clk);
    pc_valid = 1'b0; bus.arready = 1'b1;
    #1;
    n_cmp++;
    if ({bus.arvalid, stallreq_if, bus.araddr} !== {2'b11, 32'h8000_0010}) begin
      n_bad++;
      $display("FAIL flush_refetch got=%b/%h want=11/80000010",
               {bus.arvalid, stallreq_if}, bus.araddr);
    end
    @(negedge clk);
    bus.arready = 1'b0;
    beat(32'h1111_2222, 2'b00);
    #1;
    n_cmp++;
    if ({inst_valid, inst} !== {1'b1, 32'h1111_2222}) begin
      n_bad++;
      $display("FAIL flush_newinst got=%h want=%h",
               {inst_valid, inst}, {1'b1, 32'h1111_2222});
    end
    // redirect while AR is still waiting for arready
    @(negedge clk);
    quiet();
    pc = 32'h0000_0500; pc_valid = 1'b1;
    @(negedge clk);
    pc_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_cmp++;
    if ({bus.arvalid, bus.araddr} !== {1'b1, 32'h0000_0500}) begin
      n_bad++;
      $display("FAIL flush_ar_hold got=%h want=%h",
               {bus.arvalid, bus.araddr}, {1'b1, 32'h0000_0500});
    end
    @(negedge clk);
    bus.arready = 1'b1;
    @(negedge clk);
    bus.arready = 1'b0;
    beat($urandom, 2'b00);
    #1;
    n_cmp++;
    if ({inst_valid, stallreq_if} !== 2'b01) begin
      n_bad++;
      $display("FAIL flush_ar_drop got=%b want=01", {inst_valid, stallreq_if});
    end
    // redirect while holding, same cycle as the stall release
    @(negedge clk);
    quiet();
    pc = 32'h0000_0600; pc_valid = 1'b1; bus.arready = 1'b1;
    @(negedge clk);
    pc_valid = 1'b0;
    @(negedge clk);
    bus.arready = 1'b0;
    beat(32'hCAFE_F00D, 2'b00);
    stall = 4'b0111;
    #1;
    n_cmp++;
    if ({inst_valid, stallreq_if} !== 2'b00) begin
      n_bad++;
      $display("FAIL flush_pre_hold got=%b want=00", {inst_valid, stallreq_if});
    end
    @(negedge clk);
    quiet();
    flush = 1'b1;
    #1;
    n_cmp++;
    if (inst_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_hold got=%b want=0", inst_valid);
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_cmp++;
    if ({inst_valid, stallreq_if, bus.arvalid} !== 3'b000) begin
      n_bad++;
      $display("FAIL flush_hold_idle got=%b want=000",
               {inst_valid, stallreq_if, bus.arvalid});
    end
  endtask

  task automatic test_err_id();
    @(negedge clk);
    pc = 32'h0000_0700; pc_valid = 1'b1; bus.arready = 1'b1;
    @(negedge clk);
    pc_valid = 1'b0;
    @(negedge clk);
    bus.arready = 1'b0;
    beat(32'hAAAA_AAAA, 2'b00);
    bus.rid = 4'h3;
    #1;
    n_cmp++;
    if ({inst_valid, stallreq_if, bus.rready} !== 3'b011) begin
      n_bad++;
      $display("FAIL id_mismatch got=%b want=011",
               {inst_valid, stallreq_if, bus.rready});
    end
    @(negedge clk);
    beat(32'h5555_5555, 2'b10);
    #1;
    n_cmp++;
    if ({inst_valid, inst_err, inst} !== {2'b11, 32'h0}) begin
      n_bad++;
      $display("FAIL err_slverr got=%h want=%h",
               {inst_valid, inst_err, inst}, {2'b11, 32'h0});
    end
    @(negedge clk);
    quiet();
    pc = 32'h0000_0800; pc_valid = 1'b1; bus.arready = 1'b1;
    @(negedge clk);
    pc_valid = 1'b0;
    @(negedge clk);
    bus.arready = 1'b0;
    beat($urandom, 2'b11);
    stall = 4'b0111;
    @(negedge clk);
    bus.rvalid = 1'b0; bus.rlast = 1'b0;
    #1;
    n_cmp++;
    if ({inst_valid, inst} !== 33'h0) begin
      n_bad++;
      $display("FAIL err_hold got=%h want=0", {inst_valid, inst});
    end
    @(negedge clk);
    stall = 4'b0000;
    #1;
    n_cmp++;
    if ({inst_valid, inst_err, inst} !== {2'b11, 32'h0}) begin
      n_bad++;
      $display("FAIL err_release got=%h want=%h",
               {inst_valid, inst_err, inst}, {2'b11, 32'h0});
    end
    @(negedge clk);
    quiet();
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    pc = 32'h0000_0900; pc_valid = 1'b1; bus.arready = 1'b1;
    @(negedge clk);
    pc_valid = 1'b0;
    @(negedge clk);
    bus.arready = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.arvalid, bus.rready, stallreq_if, inst_valid, bus.araddr}
        !== {4'b0000, RST_PC}) begin
      n_bad++;
      $display("FAIL midrst got=%b/%h want=0000/%h",
               {bus.arvalid, bus.rready, stallreq_if, inst_valid},
               bus.araddr, RST_PC);
    end
    @(negedge clk);
    rst_n = 1'b1;
    beat(32'h7777_7777, 2'b00);
    #1;
    n_cmp++;
    if ({inst_valid, bus.rready} !== 2'b00) begin
      n_bad++;
      $display("FAIL midrst_stale got=%b want=00", {inst_valid, bus.rready});
    end
    @(negedge clk);
    quiet();
  endtask

  task automatic test_random();
    logic [32:0] exp_q[$];
    logic [32:0] front;
    logic [31:0] p, data;
    logic [1:0]  resp;
    int          ph, ard, rd, stk, issued, cyc;
    bit          bad, fl, fdone, bdone;
    bit          want_v, want_sr, want_ar, hs;
    ph = 0; issued = 0; cyc = 0;
    p = 0; data = 0; resp = 0; ard = 0; rd = 0; stk = 0;
    bad = 0; fl = 0; fdone = 0; bdone = 0;
    while (!(issued == 40 && ph == 0) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      quiet();
      want_v = 0; want_sr = 0; want_ar = 0; hs = 0;
      case (ph)
        0: begin
          p    = $urandom;
          data = $urandom;
          resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
          ard  = $urandom_range(0, 3);
          rd   = $urandom_range(0, 3);
          stk  = $urandom_range(0, 2);
          bad  = ($urandom_range(0, 3) == 0);
          fl   = ($urandom_range(0, 4) == 0);
          fdone = 0; bdone = 0;
          if (fl) begin
            rd  = rd + 1;
            stk = 0;
          end else begin
            exp_q.push_back({resp != 2'b00, (resp != 2'b00) ? 32'h0 : data});
          end
          pc = p; pc_valid = 1'b1;
          want_sr = 1; issued++; ph = 1;
        end
        1: begin
          want_sr = 1; want_ar = 1;
          if (ard == 0) begin
            bus.arready = 1'b1; hs = 1; ph = 2;
          end else begin
            ard--;
          end
        end
        2: begin
          if (rd > 0) begin
            rd--; want_sr = 1;
            if (fl && !fdone) begin
              flush = 1'b1; fdone = 1;
            end
          end else if (bad && !bdone) begin
            bdone = 1; want_sr = 1;
            beat($urandom, 2'($urandom));
            bus.rid = 4'($urandom_range(1, 15));
          end else begin
            beat(data, resp);
            stall   = (stk > 0) ? 4'b0111 : 4'b0000;
            want_sr = fl;
            want_v  = !fl && stk == 0;
            ph      = (stk > 0) ? 3 : 0;
          end
        end
        default: begin
          stk--;
          stall  = (stk > 0) ? 4'b0111 : 4'b0000;
          want_v = (stk == 0);
          if (stk == 0) ph = 0;
        end
      endcase
      #1;
      n_cmp++;
      if ({inst_valid, stallreq_if, bus.arvalid} !== {want_v, want_sr, want_ar}) begin
        n_bad++;
        $display("FAIL rnd_ctrl cyc=%0d got=%b want=%b", cyc,
                 {inst_valid, stallreq_if, bus.arvalid}, {want_v, want_sr, want_ar});
      end
      if (want_v) begin
        front = exp_q.pop_front();
        n_cmp++;
        if ({inst_err, inst} !== front) begin
          n_bad++;
          $display("FAIL rnd_inst cyc=%0d got=%h want=%h", cyc, {inst_err, inst}, front);
        end
      end
      if (hs) begin
        n_cmp++;
        if (bus.araddr !== {p[31:2], 2'b00}) begin
          n_bad++;
          $display("FAIL rnd_araddr cyc=%0d got=%h want=%h", cyc,
                   bus.araddr, {p[31:2], 2'b00});
        end
      end
    end
    n_cmp++;
    if (cyc >= 3000) begin
      n_bad++;
      $display("FAIL rnd_timeout got=%0d cycles want<3000", cyc);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL rnd_leftover got=%0d want=0", exp_q.size());
    end
    @(negedge clk);
    quiet();
  endtask

  initial begin
    rst_n = 1'b1;
    pc    = 32'h0;
    quiet();
    #1 rst_n = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_stall();
    test_flush();
    test_err_id();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
